// File: rtl/pipe_hazard_sequencer_if.sv
// Pipeline-side bundle for the hazard sequencer: ID/EXEC observation inputs,
// stall/flush controls back to the pipeline registers, and debug/perf outputs.
interface pipe_hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rd;
  logic [3:0]       id_add1;
  logic [3:0]       id_add2;
  logic [3:0]       id_add3;
  logic [3:0]       id_add4;
  logic             id_swp;
  logic             id_valid;
  logic             ex_load;
  logic             ex_wr;
  logic [3:0]       ex_wb_add;
  logic             ex_pc_write;

  logic             freeze;
  logic             fetch_inhibit;
  logic             bubble;
  logic             flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline / environment side
  modport master (
    output id_rd, id_add1, id_add2, id_add3, id_add4, id_swp, id_valid,
           ex_load, ex_wr, ex_wb_add, ex_pc_write,
    input  freeze, fetch_inhibit, bubble, flush, state, stall_cnt, flush_cnt
  );

  // sequencer side
  modport slave (
    input  id_rd, id_add1, id_add2, id_add3, id_add4, id_swp, id_valid,
           ex_load, ex_wr, ex_wb_add, ex_pc_write,
    output freeze, fetch_inhibit, bubble, flush, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EXEC, MEM, WB).
//
// state   | meaning
// --------+----------------------------------------------------------------
// RUN     | normal flow; Mealy detection of R15 write, load-use, SWP
// LSTALL  | one cycle after a load-use bubble; data now forwarded from MEM
// SWPWAIT | SWP read->write gap; front end frozen, bubbles into EXEC
// FLUSH   | wrong-path IF/ID contents being discarded after an R15 write
module pipe_hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int SWP_EXTRA    = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  pipe_hazard_sequencer_if.slave  hz_if
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LSTALL  = 2'd1,
    S_SWPWAIT = 2'd2,
    S_FLUSH   = 2'd3
  } state_e;

  localparam int MAXC = (FLUSH_CYCLES > SWP_EXTRA) ? FLUSH_CYCLES : SWP_EXTRA;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] SWP_LOAD   = CW'(SWP_EXTRA);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic hz;
  logic swp_req;
  logic freeze_w, fetch_inhibit_w, bubble_w, flush_w;

  // Load-use hazard: EXEC load result needed by any enabled ID operand (R15 included).
  assign hz = hz_if.ex_load & hz_if.ex_wr & hz_if.id_valid &
              ((hz_if.id_rd[0] & (hz_if.id_add1 == hz_if.ex_wb_add)) |
               (hz_if.id_rd[1] & (hz_if.id_add2 == hz_if.ex_wb_add)) |
               (hz_if.id_rd[2] & (hz_if.id_add3 == hz_if.ex_wb_add)) |
               (hz_if.id_rd[3] & (hz_if.id_add4 == hz_if.ex_wb_add)));

  assign swp_req = hz_if.id_swp & hz_if.id_valid;

  // State and wait counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; Mealy in RUN, Moore elsewhere.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    freeze_w        = 1'b0;
    fetch_inhibit_w = 1'b0;
    bubble_w        = 1'b0;
    flush_w         = 1'b0;
    case (state_q)
      S_RUN: begin
        if (hz_if.ex_pc_write) begin
          flush_w = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (hz) begin
          freeze_w        = 1'b1;
          fetch_inhibit_w = 1'b1;
          bubble_w        = 1'b1;
          state_d         = S_LSTALL;
        end else if (swp_req) begin
          // the SWP itself issues into EXEC, so no bubble on this first cycle
          freeze_w        = 1'b1;
          fetch_inhibit_w = 1'b1;
          if (SWP_EXTRA > 0) begin
            state_d = S_SWPWAIT;
            cnt_d   = SWP_LOAD;
          end
        end
      end
      S_LSTALL: begin
        state_d = S_RUN;
        if (hz_if.ex_pc_write) begin
          flush_w = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end
      S_SWPWAIT: begin
        freeze_w        = 1'b1;
        fetch_inhibit_w = 1'b1;
        bubble_w        = 1'b1;
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        // EXEC holds a bubble here, so a fresh ex_pc_write is ignored
        flush_w = 1'b1;
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      freeze_w        = 1'b0;
      fetch_inhibit_w = 1'b0;
      bubble_w        = 1'b0;
      flush_w         = 1'b0;
    end
  end

  // Saturating performance counters for frozen and flushed cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze_w && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_w && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz_if.freeze        = freeze_w;
  assign hz_if.fetch_inhibit = fetch_inhibit_w;
  assign hz_if.bubble        = bubble_w;
  assign hz_if.flush         = flush_w;
  assign hz_if.state         = state_q;
  assign hz_if.stall_cnt     = stall_cnt_q;
  assign hz_if.flush_cnt     = flush_cnt_q;

  // Freezing the front end while flushing it would keep a wrong-path instruction.
  a_no_flush_with_freeze: assert property (@(posedge clock) disable iff (reset)
    !(hz_if.flush && hz_if.freeze));

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-count reference model of the stall/flush rules.
module tb_pipe_hazard_sequencer;
  localparam int FC   = 2;
  localparam int SE   = 1;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipe_hazard_sequencer_if #(.CNT_W(CW)) hz_if();

  pipe_hazard_sequencer #(.FLUSH_CYCLES(FC), .SWP_EXTRA(SE), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .hz_if (hz_if)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // reference model: remaining cycles of each pending activity
  int m_flush_left = 0;
  int m_swp_left   = 0;
  bit m_lstall     = 1'b0;
  int m_stall      = 0;
  int m_flush      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    hz_if.id_rd       = 4'd0;
    hz_if.id_add1     = 4'd0;
    hz_if.id_add2     = 4'd0;
    hz_if.id_add3     = 4'd0;
    hz_if.id_add4     = 4'd0;
    hz_if.id_swp      = 1'b0;
    hz_if.id_valid    = 1'b0;
    hz_if.ex_load     = 1'b0;
    hz_if.ex_wr       = 1'b0;
    hz_if.ex_wb_add   = 4'd0;
    hz_if.ex_pc_write = 1'b0;
  endtask

  task automatic set_load_use();
    hz_if.ex_load   = 1'b1;
    hz_if.ex_wr     = 1'b1;
    hz_if.ex_wb_add = 4'd3;
    hz_if.id_rd     = 4'b0001;
    hz_if.id_add1   = 4'd3;
    hz_if.id_valid  = 1'b1;
  endtask

  task automatic rand_in();
    hz_if.id_rd       = 4'($urandom_range(0, 15));
    hz_if.id_add1     = 4'($urandom_range(0, 3));
    hz_if.id_add2     = 4'($urandom_range(0, 3));
    hz_if.id_add3     = 4'($urandom_range(0, 3));
    hz_if.id_add4     = 4'($urandom_range(12, 15));
    hz_if.id_swp      = ($urandom_range(0, 4) == 0);
    hz_if.id_valid    = ($urandom_range(0, 3) != 0);
    hz_if.ex_load     = ($urandom_range(0, 1) == 0);
    hz_if.ex_wr       = ($urandom_range(0, 3) != 0);
    hz_if.ex_wb_add   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    hz_if.ex_pc_write = ($urandom_range(0, 7) == 0);
    reset             = ($urandom_range(0, 63) == 0);
  endtask

  // Called just after a falling edge with inputs applied; checks the cycle,
  // advances the model, and returns at the next falling edge.
  task automatic step();
    bit         hzm;
    logic       e_fr, e_fi, e_bu, e_fl;
    logic [1:0] e_st;
    #1;
    hzm = hz_if.ex_load && hz_if.ex_wr && hz_if.id_valid &&
          ((hz_if.id_rd[0] && hz_if.id_add1 == hz_if.ex_wb_add) ||
           (hz_if.id_rd[1] && hz_if.id_add2 == hz_if.ex_wb_add) ||
           (hz_if.id_rd[2] && hz_if.id_add3 == hz_if.ex_wb_add) ||
           (hz_if.id_rd[3] && hz_if.id_add4 == hz_if.ex_wb_add));
    e_fr = 0; e_fi = 0; e_bu = 0; e_fl = 0;
    if (m_flush_left > 0) begin
      e_st = 2'd3; e_fl = 1;
    end else if (m_swp_left > 0) begin
      e_st = 2'd2; e_fr = 1; e_fi = 1; e_bu = 1;
    end else if (m_lstall) begin
      e_st = 2'd1; e_fl = hz_if.ex_pc_write;
    end else begin
      e_st = 2'd0;
      if (hz_if.ex_pc_write) e_fl = 1;
      else if (hzm) begin e_fr = 1; e_fi = 1; e_bu = 1; end
      else if (hz_if.id_swp && hz_if.id_valid) begin e_fr = 1; e_fi = 1; end
    end
    if (reset) begin e_fr = 0; e_fi = 0; e_bu = 0; e_fl = 0; end

    chk("ctrl{state,frz,finh,bub,flush}",
        {hz_if.state, hz_if.freeze, hz_if.fetch_inhibit, hz_if.bubble, hz_if.flush},
        {e_st, e_fr, e_fi, e_bu, e_fl});
    chk("stall_cnt", hz_if.stall_cnt, m_stall);
    chk("flush_cnt", hz_if.flush_cnt, m_flush);

    if (reset) begin
      m_flush_left = 0; m_swp_left = 0; m_lstall = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_fr && m_stall < CMAX) m_stall++;
      if (e_fl && m_flush < CMAX) m_flush++;
      if (m_flush_left > 0) m_flush_left--;
      else if (m_swp_left > 0) m_swp_left--;
      else if (m_lstall) begin
        m_lstall = 0;
        if (hz_if.ex_pc_write) m_flush_left = FC - 1;
      end else if (hz_if.ex_pc_write) m_flush_left = FC - 1;
      else if (hzm) m_lstall = 1;
      else if (hz_if.id_swp && hz_if.id_valid) m_swp_left = SE;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_state", hz_if.state, 0);
    chk("reset_outputs", {hz_if.freeze, hz_if.fetch_inhibit, hz_if.bubble, hz_if.flush}, 0);

    // load-use, then the same with the operand read masked
    set_load_use(); step();
    clr_in(); step(); step();
    chk("lu_stall_cnt", hz_if.stall_cnt, 1);
    set_load_use(); hz_if.id_rd = 4'b0000; step();
    clr_in(); step();
    chk("lu_masked_cnt", hz_if.stall_cnt, 1);

    // SWP: two frozen cycles
    do_reset();
    hz_if.id_swp = 1'b1; hz_if.id_valid = 1'b1; step();
    clr_in(); step(); step();
    chk("swp_stall_cnt", hz_if.stall_cnt, 2);

    // branch alone
    do_reset();
    hz_if.ex_pc_write = 1'b1; step();
    clr_in(); step(); step();
    chk("br_flush_cnt", hz_if.flush_cnt, 2);

    // branch together with a load-use hazard: flush only
    do_reset();
    set_load_use(); hz_if.ex_pc_write = 1'b1; step();
    clr_in(); step(); step();
    chk("br_hz_flush_cnt", hz_if.flush_cnt, 2);
    chk("br_hz_stall_cnt", hz_if.stall_cnt, 0);

    // branch arriving during LSTALL
    do_reset();
    set_load_use(); step();
    clr_in(); hz_if.ex_pc_write = 1'b1; step();
    clr_in(); step(); step();
    chk("lst_br_flush_cnt", hz_if.flush_cnt, 2);
    chk("lst_br_stall_cnt", hz_if.stall_cnt, 1);

    // reset while in SWPWAIT
    do_reset();
    hz_if.id_swp = 1'b1; hz_if.id_valid = 1'b1; step();
    clr_in();
    chk("swpwait_entered", hz_if.state, 2);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("swp_rst_state", hz_if.state, 0);
    chk("swp_rst_stall_cnt", hz_if.stall_cnt, 0);
    step();

    // back-to-back load-use stalls saturate the 4-bit counter
    do_reset();
    set_load_use();
    repeat (40) step();
    clr_in(); step();
    chk("sat_stall_cnt", hz_if.stall_cnt, CMAX);

    // randomized traffic
    do_reset();
    repeat (3000) begin
      rand_in();
      step();
    end
    reset = 1'b0;
    clr_in();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage ARM pipeline: IF, ID, EXEC, MEM, WB.
- Decides each cycle whether the front end runs, freezes with a bubble injected into EXEC, or is flushed.
- Handles three cases:
  - load-use hazards that the forwarding muxes cannot cover;
  - the two-pass SWP memory sequence;
  - writes to R15 resolved in EXEC.
- Drives the freeze on the instruction/ID-EXEC pipeline registers, the fetch inhibit, and the flush of the instruction and ID-EXEC registers. Also keeps stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after an R15 write in EXEC (IF and ID hold wrong-path instructions).
- SWP_EXTRA, 1, extra MEM cycles SWP needs between its read pass and its write pass.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rd  in  4  read enables of the ID operands: {rd4,rd3,rd2,rd1} from the ID register-read control.
- id_add1..id_add4  in  4 each  ID source addresses (src1-mux output, inst[3:0], inst[11:8], dest-mux output).
- id_swp  in  1  instruction in ID is SWP.
- id_valid  in  1  ID holds a real, non-bubble instruction.
- ex_load  in  1  instruction in EXEC is a load; its WB data exists only after MEM.
- ex_wr  in  1  write-back enable of the EXEC instruction.
- ex_wb_add  in  4  write-back address of the EXEC instruction.
- ex_pc_write  in  1  EXEC instruction writes R15 (branch or data-processing to PC) this cycle.
- freeze  out  1  hold the instruction register and the ID stage; the forwarding muxes keep their selects.
- fetch_inhibit  out  1  block PC write and instruction read.
- bubble  out  1  load zero controls into the ID-EXEC register this cycle.
- flush  out  1  zero the instruction register and the ID-EXEC register.
- state  out  2  current FSM state (debug).
- stall_cnt  out  CNT_W  cycles with freeze=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Reset values: state=RUN, freeze=0, fetch_inhibit=0, bubble=0, flush=0, both counters 0, internal down-counter 0.
- States and encodings: RUN=0, LSTALL=1, SWPWAIT=2, FLUSH=3.
- Hazard term: hz = ex_load & ex_wr & id_valid & OR over i of (id_rd[i] & id_add_i==ex_wb_add). R15 reads are included.
- Outputs are Mealy in RUN (combinational, same cycle as detection) and Moore in the other states.
- RUN, priority order:
  1. ex_pc_write=1: flush=1 this cycle; go to FLUSH with cnt=FLUSH_CYCLES-1.
  2. else hz=1: freeze=1, fetch_inhibit=1, bubble=1; go to LSTALL.
  3. else id_swp & id_valid: freeze=1, fetch_inhibit=1, bubble=0 (the SWP itself issues); go to SWPWAIT with cnt=SWP_EXTRA.
  4. else all outputs 0; stay in RUN.
- LSTALL:
  - Exactly one cycle; all outputs 0; return to RUN.
  - The loaded value is now forwarded from MEM by the existing forwarding path.
  - If ex_pc_write=1 in this cycle: flush=1 and go to FLUSH instead.
- SWPWAIT:
  - freeze=1, fetch_inhibit=1, bubble=1 each cycle; cnt decrements.
  - Return to RUN when cnt reaches 0 (the cycle with cnt=0 still asserts outputs).
  - SWP_EXTRA=1 gives 2 frozen cycles total, counting the RUN entry cycle.
- FLUSH:
  - flush=1 and fetch_inhibit=0 (fetch from the new PC proceeds); freeze=0.
  - Decrement cnt; go to RUN after the cycle where cnt=0.
  - A new ex_pc_write during FLUSH is a don't-care: EXEC holds a bubble.
- Simultaneous events:
  - ex_pc_write beats hz and SWP; hz beats SWP. A younger SWP waits until the hazard clears.
  - flush and freeze are never 1 in the same cycle (checked by assertion).
- Reset mid-operation: any state goes to RUN next edge, outputs 0 in that cycle. The counters also clear.
- Counters:
  - Increment by 1 per cycle with freeze=1 (stall_cnt) or flush=1 (flush_cnt).
  - Hold at 2^CNT_W-1; no wrap.
- id_rd=0 for an operand masks its address compare; id_valid=0 disables hz and SWP detection.

Test Plan:
- Load-use: ex_load=1, ex_wr=1, ex_wb_add=3, id_rd=0001, id_add1=3 → freeze/fetch_inhibit/bubble=1 for exactly 1 cycle, state 0→1→0, stall_cnt=1. Repeat with id_rd=0000 → no stall.
- SWP with SWP_EXTRA=1: id_swp=1, id_valid=1 → freeze=1 for 2 cycles, bubble 0 then 1, state 0→2→0, stall_cnt=2.
- Branch: ex_pc_write=1 pulse in RUN → flush=1 for 2 cycles, fetch_inhibit=0, flush_cnt=2. Asserted together with hz → no freeze, flush only.
- Branch during LSTALL → next state FLUSH, flush=1 for 2 cycles, freeze never coincident with flush.
- Reset asserted in SWPWAIT with cnt=1 → next edge state=0, all outputs 0, counters 0.
- Counter saturation with CNT_W=4: 20 back-to-back load-use stalls → stall_cnt stops at 15.
